// File: rtl/hermes_pkt_sink_if.sv
// Flit-receive and record-drain signals of the Hermes packet sink.
// The _i/_o suffixes are seen from the sink; master is the router/consumer side.
interface hermes_pkt_sink_if;
  logic        rx_i;
  logic [31:0] data_i;
  logic        credit_o;
  logic [31:0] now_i;
  logic        rec_valid_o;
  logic        rec_ready_i;
  logic [15:0] rec_src_o;
  logic [31:0] rec_size_o;
  logic [31:0] rec_pktnum_o;
  logic [31:0] rec_latency_o;
  logic        rec_err_o;
  logic [15:0] pkt_cnt_o;
  logic [15:0] err_cnt_o;

  modport master (
    output rx_i, data_i, now_i, rec_ready_i,
    input  credit_o, rec_valid_o, rec_src_o, rec_size_o, rec_pktnum_o,
    input  rec_latency_o, rec_err_o, pkt_cnt_o, err_cnt_o
  );

  modport slave (
    input  rx_i, data_i, now_i, rec_ready_i,
    output credit_o, rec_valid_o, rec_src_o, rec_size_o, rec_pktnum_o,
    output rec_latency_o, rec_err_o, pkt_cnt_o, err_cnt_o
  );
endinterface

// File: rtl/hermes_pkt_sink.sv
// Hermes local-port packet sink: parses test packets under credit flow control,
// checks address/payload, measures latency and queues one record per packet.
module hermes_pkt_sink #(
  parameter int X_ADDR    = 0,
  parameter int Y_ADDR    = 0,
  parameter int REC_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  hermes_pkt_sink_if.slave bus
);

  localparam int              PW       = $clog2(REC_DEPTH);
  localparam logic [31:0]     X_W      = X_ADDR;
  localparam logic [31:0]     Y_W      = Y_ADDR;
  localparam logic [15:0]     MY_ADDR  = {X_W[7:0], Y_W[7:0]};
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(REC_DEPTH);

  typedef enum logic [2:0] {
    S_HDR,
    S_SIZE,
    S_TS,
    S_NUM,
    S_PAY
  } state_t;

  typedef struct packed {
    logic [15:0] src;
    logic [31:0] size;
    logic [31:0] pktnum;
    logic [31:0] latency;
    logic        err;
  } rec_t;

  state_t        state_q, state_d;
  logic [15:0]   src_q, src_d;
  logic [31:0]   size_q, size_d;
  logic [31:0]   latency_q, latency_d;
  logic [31:0]   pktnum_q, pktnum_d;
  logic [31:0]   idx_q, idx_d;
  logic          dst_err_q, dst_err_d;
  logic          size_err_q, size_err_d;
  logic          pay_err_q, pay_err_d;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic [15:0]   pkt_cnt_q, err_cnt_q;
  rec_t          mem_q [REC_DEPTH];

  logic          credit, accept, push, pop, rec_valid;
  logic          pay_err_now;
  logic [31:0]   lat_now;
  rec_t          rec_d, head;

  // Credit only looks at the pre-cycle count, so a same-cycle pop cannot
  // open a slot for the flit that completes a packet.
  assign credit      = (count_q != FULL_CNT);
  assign accept      = bus.rx_i && credit;
  assign rec_valid   = (count_q != '0);
  assign pop         = rec_valid && bus.rec_ready_i;
  assign lat_now     = bus.now_i - bus.data_i;
  assign pay_err_now = pay_err_q | (bus.data_i != (idx_q - 32'd1));

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    size_d     = size_q;
    latency_d  = latency_q;
    pktnum_d   = pktnum_q;
    idx_d      = idx_q;
    dst_err_d  = dst_err_q;
    size_err_d = size_err_q;
    pay_err_d  = pay_err_q;
    push       = 1'b0;
    rec_d      = '0;
    if (accept) begin
      case (state_q)
        S_HDR: begin
          src_d     = bus.data_i[31:16];
          dst_err_d = (bus.data_i[15:0] != MY_ADDR);
          pay_err_d = 1'b0;
          state_d   = S_SIZE;
        end
        S_SIZE: begin
          size_d     = bus.data_i;
          size_err_d = (bus.data_i < 32'd2);
          if (bus.data_i == 32'd0) begin
            push    = 1'b1;
            rec_d   = '{src: src_q, size: bus.data_i, pktnum: 32'd0,
                        latency: 32'd0, err: 1'b1};
            state_d = S_HDR;
          end else begin
            state_d = S_TS;
          end
        end
        S_TS: begin
          latency_d = lat_now;
          if (size_q == 32'd1) begin
            push    = 1'b1;
            rec_d   = '{src: src_q, size: size_q, pktnum: 32'd0, latency: lat_now,
                        err: dst_err_q | size_err_q | pay_err_q};
            state_d = S_HDR;
          end else begin
            state_d = S_NUM;
          end
        end
        S_NUM: begin
          pktnum_d = bus.data_i;
          idx_d    = 32'd4;
          if (size_q == 32'd2) begin
            push    = 1'b1;
            rec_d   = '{src: src_q, size: size_q, pktnum: bus.data_i,
                        latency: latency_q, err: dst_err_q | size_err_q | pay_err_q};
            state_d = S_HDR;
          end else begin
            state_d = S_PAY;
          end
        end
        S_PAY: begin
          pay_err_d = pay_err_now;
          idx_d     = idx_q + 32'd1;
          if (idx_q == size_q + 32'd1) begin
            push    = 1'b1;
            rec_d   = '{src: src_q, size: size_q, pktnum: pktnum_q,
                        latency: latency_q, err: dst_err_q | size_err_q | pay_err_now};
            state_d = S_HDR;
          end
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_HDR;
      src_q      <= '0;
      size_q     <= '0;
      latency_q  <= '0;
      pktnum_q   <= '0;
      idx_q      <= '0;
      dst_err_q  <= 1'b0;
      size_err_q <= 1'b0;
      pay_err_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      size_q     <= size_d;
      latency_q  <= latency_d;
      pktnum_q   <= pktnum_d;
      idx_q      <= idx_d;
      dst_err_q  <= dst_err_d;
      size_err_q <= size_err_d;
      pay_err_q  <= pay_err_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (push && rec_d.err && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REC_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= rec_d;
    end
  end

  // Data outputs read as zero whenever the queue is empty.
  assign head              = mem_q[rd_ptr_q];
  assign bus.credit_o      = credit;
  assign bus.rec_valid_o   = rec_valid;
  assign bus.rec_src_o     = rec_valid ? head.src     : '0;
  assign bus.rec_size_o    = rec_valid ? head.size    : '0;
  assign bus.rec_pktnum_o  = rec_valid ? head.pktnum  : '0;
  assign bus.rec_latency_o = rec_valid ? head.latency : '0;
  assign bus.rec_err_o     = rec_valid ? head.err     : 1'b0;
  assign bus.pkt_cnt_o     = pkt_cnt_q;
  assign bus.err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_hermes_pkt_sink.sv
// Directed bench for hermes_pkt_sink with X_ADDR=1, Y_ADDR=2, REC_DEPTH=4.
module tb_hermes_pkt_sink;

  typedef struct packed {
    logic [15:0] src;
    logic [31:0] size;
    logic [31:0] pktnum;
    logic [31:0] lat;
    logic        err;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  hermes_pkt_sink_if bus ();

  hermes_pkt_sink #(
    .X_ADDR   (1),
    .Y_ADDR   (2),
    .REC_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic string fmt(input rec_t r);
    return $sformatf("src=%h size=%0d pktnum=%0d lat=%0d err=%0b", r.src, r.size, r.pktnum, r.lat, r.err);
  endfunction

  task automatic send_flit(input logic [31:0] d, input logic [31:0] n);
    int guard = 0;
    @(negedge clk);
    bus.rx_i   = 1'b1;
    bus.data_i = d;
    bus.now_i  = n;
    while (!bus.credit_o && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL credit_wait got credit_o=0 for 300 cycles, need 1");
    end
    @(posedge clk);
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input logic [31:0] size, input logic [31:0] ts,
                          input logic [31:0] num, input logic [31:0] now, input int bad_idx,
                          input logic [31:0] bad_val, input bit bubbles);
    logic [31:0] f;
    int total = int'(size) + 2;
    for (int i = 0; i < total; i++) begin
      case (i)
        0:       f = hdr;
        1:       f = size;
        2:       f = ts;
        3:       f = num;
        default: f = (i == bad_idx) ? bad_val : 32'(i - 1);
      endcase
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          bus.rx_i = 1'b0;
        end
      end
      send_flit(f, now);
    end
    #1 bus.rx_i = 1'b0;
  endtask

  task automatic pop_rec(output rec_t r, output logic [15:0] pc, output logic [15:0] ec);
    int guard = 0;
    @(negedge clk);
    while (!bus.rec_valid_o && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL rec_wait got rec_valid_o=0 for 300 cycles, need 1");
    end
    r  = '{bus.rec_src_o, bus.rec_size_o, bus.rec_pktnum_o, bus.rec_latency_o, bus.rec_err_o};
    pc = bus.pkt_cnt_o;
    ec = bus.err_cnt_o;
    $display("record %s pkt_cnt=%0d err_cnt=%0d", fmt(r), pc, ec);
    bus.rec_ready_i = 1'b1;
    @(negedge clk);
    bus.rec_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.rx_i = 1'b0; bus.data_i = '0; bus.now_i = '0; bus.rec_ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.rec_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b need 0", bus.rec_valid_o); end
    vectors++;
    if (bus.credit_o !== 1'b1) begin miscompares++; $display("FAIL reset_credit got %b need 1", bus.credit_o); end
    vectors++;
    if (bus.pkt_cnt_o !== 16'd0 || bus.err_cnt_o !== 16'd0) begin
      miscompares++; $display("FAIL reset_counts got pkt=%0d err=%0d need 0 0", bus.pkt_cnt_o, bus.err_cnt_o);
    end
    vectors++;
    if ({bus.rec_src_o, bus.rec_size_o, bus.rec_pktnum_o, bus.rec_latency_o, bus.rec_err_o} !== '0) begin
      miscompares++; $display("FAIL reset_rec_data got nonzero rec_* need all 0");
    end
  endtask

  task automatic test_basic();
    rec_t r, e;
    logic [15:0] pc, ec;
    send_pkt(32'h00000102, 32'd6, 32'd100, 32'h000186A0, 32'd140, -1, 32'd0, 1'b0);
    pop_rec(r, pc, ec);
    e = '{16'h0000, 32'd6, 32'd100000, 32'd40, 1'b0};
    vectors++;
    if (r !== e) begin miscompares++; $display("FAIL basic_rec got %s need %s", fmt(r), fmt(e)); end
    vectors++;
    if (pc !== 16'd1 || ec !== 16'd0) begin miscompares++; $display("FAIL basic_cnt got %0d/%0d need 1/0", pc, ec); end
    vectors++;
    if (bus.rec_valid_o !== 1'b0) begin miscompares++; $display("FAIL basic_drained got valid=%b need 0", bus.rec_valid_o); end
  endtask

  task automatic test_errors();
    rec_t r, e;
    logic [15:0] pc, ec;
    send_pkt(32'h00000301, 32'd6, 32'd100, 32'h000186A0, 32'd140, -1, 32'd0, 1'b0);
    pop_rec(r, pc, ec);
    e = '{16'h0000, 32'd6, 32'd100000, 32'd40, 1'b1};
    vectors++;
    if (r !== e) begin miscompares++; $display("FAIL dst_err_rec got %s need %s", fmt(r), fmt(e)); end
    vectors++;
    if (pc !== 16'd2 || ec !== 16'd1) begin miscompares++; $display("FAIL dst_err_cnt got %0d/%0d need 2/1", pc, ec); end
    send_pkt(32'h00000102, 32'd6, 32'd100, 32'h000186A0, 32'd140, 5, 32'd9, 1'b0);
    pop_rec(r, pc, ec);
    vectors++;
    if (r !== e) begin miscompares++; $display("FAIL pay_err_rec got %s need %s", fmt(r), fmt(e)); end
    vectors++;
    if (pc !== 16'd3 || ec !== 16'd2) begin miscompares++; $display("FAIL pay_err_cnt got %0d/%0d need 3/2", pc, ec); end
  endtask

  task automatic test_short();
    rec_t r, e;
    logic [15:0] pc, ec;
    send_pkt(32'hABCD0102, 32'd0, 32'd0, 32'd0, 32'd999, -1, 32'd0, 1'b0);
    pop_rec(r, pc, ec);
    e = '{16'hABCD, 32'd0, 32'd0, 32'd0, 1'b1};
    vectors++;
    if (r !== e) begin miscompares++; $display("FAIL size0_rec got %s need %s", fmt(r), fmt(e)); end
    send_pkt(32'h12340102, 32'd2, 32'd500, 32'd77, 32'd510, -1, 32'd0, 1'b0);
    pop_rec(r, pc, ec);
    e = '{16'h1234, 32'd2, 32'd77, 32'd10, 1'b0};
    vectors++;
    if (r !== e) begin miscompares++; $display("FAIL size2_rec got %s need %s", fmt(r), fmt(e)); end
    send_pkt(32'h00000102, 32'd1, 32'd50, 32'd0, 32'd80, -1, 32'd0, 1'b0);
    pop_rec(r, pc, ec);
    e = '{16'h0000, 32'd1, 32'd0, 32'd30, 1'b1};
    vectors++;
    if (r !== e) begin miscompares++; $display("FAIL size1_rec got %s need %s", fmt(r), fmt(e)); end
    vectors++;
    if (pc !== 16'd6 || ec !== 16'd4) begin miscompares++; $display("FAIL short_cnt got %0d/%0d need 6/4", pc, ec); end
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int k = 0; k < 5; k++)
          send_pkt(32'h00000102, 32'd4, 32'd1000, 32'(10 + k), 32'd1005, -1, 32'd0, 1'b0);
      end
      begin
        rec_t r, e;
        logic [15:0] pc, ec;
        int guard = 0;
        while (bus.pkt_cnt_o != 16'd10 && guard < 500) begin
          @(negedge clk);
          guard++;
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (bus.credit_o !== 1'b0) begin miscompares++; $display("FAIL full_credit got %b need 0", bus.credit_o); end
        vectors++;
        if (bus.pkt_cnt_o !== 16'd10) begin miscompares++; $display("FAIL full_stall got pkt_cnt=%0d need 10", bus.pkt_cnt_o); end
        for (int k = 0; k < 5; k++) begin
          pop_rec(r, pc, ec);
          e = '{16'h0000, 32'd4, 32'(10 + k), 32'd5, 1'b0};
          vectors++;
          if (r !== e) begin miscompares++; $display("FAIL fifo_order%0d got %s need %s", k, fmt(r), fmt(e)); end
        end
      end
    join
    vectors++;
    if (bus.pkt_cnt_o !== 16'd11 || bus.err_cnt_o !== 16'd4) begin
      miscompares++; $display("FAIL b2b_cnt got %0d/%0d need 11/4", bus.pkt_cnt_o, bus.err_cnt_o);
    end
  endtask

  task automatic test_wrap_and_bubbles();
    rec_t r, e;
    logic [15:0] pc, ec;
    send_pkt(32'h00000102, 32'd2, 32'hFFFFFFF0, 32'd3, 32'h00000010, -1, 32'd0, 1'b0);
    pop_rec(r, pc, ec);
    e = '{16'h0000, 32'd2, 32'd3, 32'h20, 1'b0};
    vectors++;
    if (r !== e) begin miscompares++; $display("FAIL wrap_rec got %s need %s", fmt(r), fmt(e)); end
    e = '{16'h0000, 32'd8, 32'd55, 32'd60, 1'b0};
    send_pkt(32'h00000102, 32'd8, 32'd200, 32'd55, 32'd260, -1, 32'd0, 1'b0);
    pop_rec(r, pc, ec);
    vectors++;
    if (r !== e) begin miscompares++; $display("FAIL clean10_rec got %s need %s", fmt(r), fmt(e)); end
    send_pkt(32'h00000102, 32'd8, 32'd200, 32'd55, 32'd260, -1, 32'd0, 1'b1);
    pop_rec(r, pc, ec);
    vectors++;
    if (r !== e) begin miscompares++; $display("FAIL bubble10_rec got %s need %s", fmt(r), fmt(e)); end
    vectors++;
    if (pc !== 16'd14) begin miscompares++; $display("FAIL bubble_cnt got %0d need 14", pc); end
  endtask

  task automatic test_mid_reset();
    rec_t r, e;
    logic [15:0] pc, ec;
    send_flit(32'h00000102, 32'd0);
    send_flit(32'd6, 32'd0);
    send_flit(32'd100, 32'd140);
    #1 bus.rx_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (bus.pkt_cnt_o !== 16'd0 || bus.err_cnt_o !== 16'd0) begin
      miscompares++; $display("FAIL midrst_cnt got %0d/%0d need 0/0", bus.pkt_cnt_o, bus.err_cnt_o);
    end
    vectors++;
    if (bus.credit_o !== 1'b1) begin miscompares++; $display("FAIL midrst_credit got %b need 1", bus.credit_o); end
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.rec_valid_o !== 1'b0) begin miscompares++; $display("FAIL midrst_norec got valid=%b need 0", bus.rec_valid_o); end
    send_pkt(32'h00000102, 32'd6, 32'd100, 32'h000186A0, 32'd140, -1, 32'd0, 1'b0);
    pop_rec(r, pc, ec);
    e = '{16'h0000, 32'd6, 32'd100000, 32'd40, 1'b0};
    vectors++;
    if (r !== e) begin miscompares++; $display("FAIL midrst_rec got %s need %s", fmt(r), fmt(e)); end
    vectors++;
    if (pc !== 16'd1 || ec !== 16'd0) begin miscompares++; $display("FAIL midrst_after_cnt got %0d/%0d need 1/0", pc, ec); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_short();
    test_back_to_back();
    test_wrap_and_bubbles();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hermes_pkt_sink.md
Name: hermes_pkt_sink

Overview:
- Synthesizable consumer for one Hermes router local output port (tx/data/credit side); replaces the behavioural receive loop in system-level and FPGA builds.
- Accepts flits under credit flow control and parses the standard test-packet format: header, size, timestamp, packet number, payload.
- Checks the destination address and payload contents, and computes latency against a shared timestamp counter.
- Pushes one result record per packet into an internal FIFO, which is drained over a valid/ready interface.

Parameters:
- X_ADDR, 0, x coordinate of the attached router (8 bits used)
- Y_ADDR, 0, y coordinate of the attached router (8 bits used)
- REC_DEPTH, 4, record FIFO depth; power of two, >= 2

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rx_i  in  1  flit valid from router local output (router tx)
- data_i  in  32  flit data
- credit_o  out  1  sink can accept a flit this cycle (router credit_i)
- now_i  in  32  free-running timestamp shared with the injectors
- rec_valid_o  out  1  record available at FIFO head
- rec_ready_i  in  1  consumer takes the head record
- rec_src_o  out  16  source {x[7:0],y[7:0]} taken from header flit bits [31:16]
- rec_size_o  out  32  size flit value
- rec_pktnum_o  out  32  packet-number flit value
- rec_latency_o  out  32  now_i at timestamp-flit acceptance minus timestamp flit, modulo 2^32
- rec_err_o  out  1  OR of dst_err, size_err, payload_err for this packet
- pkt_cnt_o  out  16  packets completed; saturates at 0xFFFF
- err_cnt_o  out  16  packets completed with rec_err set; saturates at 0xFFFF

Behaviour:
- Flit accept = rx_i && credit_o.
- credit_o = (fifo_count != REC_DEPTH). This is combinational from registered state and does not depend on rx_i.
- Packet framing: the total length is size+2 flits.
  - flit0 = {src_x, src_y, dst_x, dst_y}
  - flit1 = size
  - flit2 = timestamp
  - flit3 = packet number
  - flit i (4 <= i <= size+1) must equal i-1
- FSM states: HDR, SIZE, TS, NUM, PAY. The FSM advances only on flit accept.
  - HDR -> SIZE. Latch src = data_i[31:16]. Set dst_err = (data_i[15:0] != {X_ADDR[7:0], Y_ADDR[7:0]}). Clear payload_err.
  - SIZE -> TS. Latch size. size_err = (size < 2).
    - size==0: the packet ends on this flit; push the record with pktnum=0 and latency=0, then go to HDR.
  - TS -> NUM. Latch latency = now_i - data_i, using 32-bit wrapping subtraction.
    - size==1: the packet ends here; push the record with pktnum=0, then go to HDR.
  - NUM -> PAY. Latch pktnum. Set idx=4.
    - size==2: push the record, then go to HDR.
  - PAY: compare data_i with idx-1 and set payload_err on mismatch (sticky for the packet). Increment idx.
    - When idx == size+1: push the record, then go to HDR.
- idx and size compare as 32-bit unsigned values.
- Record push happens in the cycle the last flit is accepted. The record is visible on rec_* the next cycle.
- Bubbles: rx_i may drop between flits at any point. The FSM holds its state, with no timeout.
- FIFO full: credit_o=0, so no flit is accepted and the packet stalls mid-stream. A push therefore never finds the FIFO full.
- Simultaneous pop and push: allowed. The count is unchanged and credit_o is computed from the pre-cycle count.
- Pop = rec_valid_o && rec_ready_i. rec_* outputs are stable while rec_valid_o=1 and rec_ready_i=0.
- pkt_cnt_o increments on every push. err_cnt_o increments on every push with error. Both saturate.
- Reset (any time, including mid-packet):
  - FSM returns to HDR and the FIFO is flushed.
  - rec_valid_o=0, credit_o=1 (count=0).
  - pkt_cnt_o=0, err_cnt_o=0.
  - All latched fields and the rec_* data outputs are 0.
  - A partial packet in flight is discarded without a record.

Test Plan:
- X_ADDR=1, Y_ADDR=2. Send 8 flits 0x00000102, 6, ts=100, 0x186A0, 3, 4, 5, 6 with now_i=140 at the ts flit -> one record: src=0x0000, size=6, pktnum=100000, latency=40, err=0; pkt_cnt=1.
- Same packet with flit0=0x00000301 -> record err=1 (dst); err_cnt=1. Payload flit 4 changed to 9 -> err=1.
- size=0 packet (2 flits) -> record size=0, err=1. size=2 packet (4 flits, no payload) -> err=0.
- Hold rec_ready_i=0 and send REC_DEPTH+1 back-to-back packets -> credit_o drops after the 4th record push and the 5th packet stalls. Raise rec_ready_i -> records pop in order, and the 5th completes with correct fields.
- ts=0xFFFFFFF0, now_i=0x00000010 at acceptance -> latency=0x20. Random rx_i bubbles on a 10-flit packet -> the record is identical to the bubble-free case.
- Assert rst_n=0 for one cycle after flit 3 of a packet -> no record, counters 0, credit_o=1. A following clean packet parses correctly.
